// File: rtl/btn_debounce_pulse_pkg.sv
// Shared state encodings and default sizing for the button
// debouncer and its bench.
package btn_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Raw button in, debounced level/pulses/busy out.
// master drives the button, slave is the debouncer.
interface btn_debounce_pulse_if;

  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output busy
  );

endinterface

// File: rtl/btn_debounce_pulse_sync_chain.sv
// Parameterised flop chain bringing an asynchronous bit into
// the clk domain, cleared by synchronous reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: synchronizer, 4-state debounce FSM,
// registered level, edge pulses and busy flag.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_debounce_pulse_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (sync_q)
  );

  // Saturate rather than wrap if the qualifier ever overstays.
  assign cnt_inc = (cnt_q >= CNT_LAST) ? CNT_LAST
                                       : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE_LO: begin
        if (sync_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sync_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_STABLE_HI: begin
        if (!sync_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sync_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
    endcase
    busy_d = (state_d == ST_WAIT_HI) ||
             (state_d == ST_WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.busy      = busy_q;

  cnt_never_wraps: assert property (
    @(posedge clk) disable iff (reset) cnt_q <= CNT_LAST
  );

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse with a sliding-window
// reference model of the debounce rules.
module tb_btn_debounce_pulse;
  import btn_debounce_pulse_pkg::*;

  localparam int S = 2;
  localparam int D = 4;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  btn_debounce_pulse_if bus ();

  btn_debounce_pulse #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dut_rises = 0;
  int   dut_falls = 0;

  // Model: input delay line of S samples, window of last D
  // synced samples; the level flips when the whole window
  // disagrees with it.
  bit pipe[$];
  bit hist[$];
  bit m_level;

  task automatic step(input bit rst, input bit b);
    exp_t e;
    bit   s;
    bit   flip;
    reset      = rst;
    bus.btn_in = b;
    e = '0;
    if (rst) begin
      pipe.delete();
      repeat (S) pipe.push_back(1'b0);
      hist.delete();
      m_level = 1'b0;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(b);
      hist.push_back(s);
      if (hist.size() > D) void'(hist.pop_front());
      flip = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
      e.rise = flip && !m_level;
      e.fall = flip && m_level;
      if (flip) m_level = !m_level;
      e.level = m_level;
      e.busy  = !flip && (s != m_level);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) step(1'b0, b);
  endtask

  task automatic chk(input string nm, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      a = {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.busy};
      if (a.rise) dut_rises++;
      if (a.fall) dut_falls++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty cyc=%0d", cyc);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d lvl/rise/fall/busy got %b required %b",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin
    int r0;
    int f0;
    bit v;
    int n;

    // Reset held with button pressed, then rise after release
    repeat (3) step(1'b1, 1'b1);
    r0 = dut_rises;
    hold(1'b1, 10);
    chk("rst_then_rise", dut_rises - r0, 1);

    // Release
    f0 = dut_falls;
    hold(1'b0, 10);
    chk("first_fall", dut_falls - f0, 1);

    // Clean press
    r0 = dut_rises;
    hold(1'b1, 12);
    chk("clean_press", dut_rises - r0, 1);
    hold(1'b0, 10);

    // Bounce then steady high
    r0 = dut_rises;
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("bounce_no_pulse", dut_rises - r0, 0);
    hold(1'b1, 12);
    chk("bounce_one_rise", dut_rises - r0, 1);

    // Release from stable high
    r0 = dut_rises;
    f0 = dut_falls;
    hold(1'b0, 12);
    chk("release_fall", dut_falls - f0, 1);
    chk("release_no_rise", dut_rises - r0, 0);

    // Reset aborts qualification at counter 2
    r0 = dut_rises;
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    chk("abort_busy", int'(bus.busy), 0);
    hold(1'b0, 8);
    chk("abort_no_rise", dut_rises - r0, 0);

    // Long hold
    r0 = dut_rises;
    hold(1'b1, 200);
    chk("long_hold_rise", dut_rises - r0, 1);
    chk("long_hold_level", int'(bus.btn_level), 1);
    hold(1'b0, 10);

    // Random bouncing with occasional reset
    repeat (60) begin
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 24) == 0) step(1'b1, v);
      hold(v, n);
    end
    hold(1'b0, 10);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
